bp_cache_req_arbiter: RTL and testbench
=======================================

BP_CACHE_REQ_ARBITER -- requirements
Module: bp_cache_req_arbiter

Interface
REQ-001 SHALL have parameter req_width_p, default 64, meaning width of one packed cache request.
REQ-002 SHALL have parameter metadata_width_p, default 8, meaning width of one packed request-metadata word.
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1, meaning reset: asynchronous, active-low.
REQ-005 SHALL have port cache_req_i, input, 2 x req_width_p, meaning requests: index 0 is the icache, index 1 is the dcache.
REQ-006 SHALL have port cache_req_v_i, input, 2, meaning per-requester request valid.
REQ-007 SHALL have port cache_req_ready_o, output, 2, meaning per-requester request ready.
REQ-008 SHALL have port cache_req_metadata_i, input, 2 x metadata_width_p, meaning per-requester metadata.
REQ-009 SHALL have port cache_req_metadata_v_i, input, 2, meaning per-requester metadata valid (single-cycle pulse).
REQ-010 SHALL have port cache_req_complete_o, output, 2, meaning per-requester completion pulse.
REQ-011 SHALL have port cache_req_o, output, req_width_p, meaning request to the LCE.
REQ-012 SHALL have port cache_req_v_o, output, 1, meaning request valid to the LCE.
REQ-013 SHALL have port cache_req_ready_i, input, 1, meaning LCE ready.
REQ-014 SHALL have port cache_req_metadata_o, output, metadata_width_p, meaning metadata to the LCE.
REQ-015 SHALL have port cache_req_metadata_v_o, output, 1, meaning metadata valid pulse to the LCE.
REQ-016 SHALL have port cache_req_complete_i, input, 1, meaning LCE completion pulse.
REQ-017 SHALL have port owner_o, output, 1, meaning index of the requester currently holding the grant; LCE fill packets are steered with it.

Function
REQ-018 SHALL implement FSM states IDLE, SEND, META, BUSY.
REQ-019 In IDLE, cache_req_ready_o[i] SHALL equal 1 only for the requester selected by round-robin; all other ready bits SHALL be 0.
REQ-020 Round-robin selection SHALL work as follows: if exactly one requester is valid, select it; if both are valid, select the requester not equal to last_owner.
REQ-021 On an IDLE handshake (v_i and ready_o both high for index i), the block SHALL register cache_req_i[i] and set owner to i, then go to SEND.
REQ-022 In SEND, cache_req_v_o SHALL be 1 with the registered request; on cache_req_ready_i = 1 the block SHALL go to META, or to BUSY if metadata is already captured.
REQ-023 cache_req_metadata_v_i[owner] SHALL be captured, with a captured flag set, in any of SEND, META or BUSY, and also in the same cycle as the IDLE handshake.
REQ-024 Metadata pulses from the non-owner SHALL be ignored.
REQ-025 cache_req_metadata_v_o SHALL pulse for exactly one cycle carrying the captured metadata, in the cycle after both the request has been sent and the metadata has been captured; the FSM is then in BUSY.
REQ-026 In BUSY, cache_req_complete_i SHALL drive cache_req_complete_o[owner] high combinationally in the same cycle, update last_owner to owner, clear the captured flag, and return the FSM to IDLE.
REQ-027 A new grant SHALL be issued no earlier than the cycle after completion.
REQ-028 cache_req_complete_i arriving outside BUSY SHALL be ignored and SHALL fire a simulation assertion.
REQ-029 cache_req_ready_o SHALL be all-zero in SEND, META and BUSY.
REQ-030 cache_req_v_o SHALL be 0 outside SEND.
REQ-031 Throughput SHALL be at most one outstanding request; minimum latency is 1 cycle from the upstream handshake to cache_req_v_o.

Reset
REQ-032 Asserting reset_n_i low SHALL immediately force: state = IDLE, last_owner = 1 (so icache wins the first tie), owner = 0, captured flag = 0, and all valid, ready and complete outputs low except IDLE ready.
REQ-033 Reset asserted mid-transaction SHALL drop the transaction silently, with no completion pulse.
REQ-034 Data registers need no reset.

Structure
REQ-035 The state enum bp_cache_req_arb_state_e SHALL be placed in bp_common_pkg.
REQ-036 No sub-module SHALL be required; the round-robin pick MAY use bsg_arb_round_robin.

Verification
REQ-037 Scenario, single request: only v_i[1] with request 0xABCD, ready_i = 1 -> cache_req_v_o high 1 cycle later with 0xABCD; after metadata 0x5 and complete_i, complete_o = 2'b10.
REQ-038 Scenario, tie after reset: both valid -> icache granted first (owner_o = 0); after its completion, dcache granted next (owner_o = 1).
REQ-039 Scenario, early metadata: metadata_v_i[0] in the same cycle as the IDLE handshake, ready_i held 0 for 3 cycles -> metadata_v_o pulses once, the cycle after the ready_i handshake.
REQ-040 Scenario, stray signals: complete_i pulse in IDLE -> no complete_o and the assertion fires; non-owner metadata pulse in BUSY -> metadata register unchanged.
REQ-041 Scenario, reset mid-operation: reset_n_i low while in BUSY -> outputs drop immediately, complete_o stays 0, and the next tie grants the icache.

Source files
------------

// File: rtl/bp_common_pkg.sv
// Shared types and helpers for the cache request arbiter.
package bp_common_pkg;

    localparam int unsigned num_cache_req_lp = 2;

    typedef enum logic [1:0] {
        e_arb_idle,
        e_arb_send,
        e_arb_meta,
        e_arb_busy
    } bp_cache_req_arb_state_e;

    // Single requester wins outright; on a tie (or no request) favour the one that did not go last.
    function automatic logic rr_pick(input logic [1:0] v, input logic last_owner);
        case (v)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~last_owner;
        endcase
    endfunction

endpackage

// File: rtl/bp_cache_req_arbiter.sv
// Arbitrates icache/dcache requests onto a single LCE request port,
// holding one outstanding request and forwarding its metadata exactly once.
module bp_cache_req_arbiter
    import bp_common_pkg::*;
#(
    parameter int unsigned req_width_p      = 64,
    parameter int unsigned metadata_width_p = 8
) (
    input  logic                                               clk_i,
    input  logic                                               reset_n_i,
    input  logic [num_cache_req_lp-1:0][req_width_p-1:0]      cache_req_i,
    input  logic [num_cache_req_lp-1:0]                        cache_req_v_i,
    output logic [num_cache_req_lp-1:0]                        cache_req_ready_o,
    input  logic [num_cache_req_lp-1:0][metadata_width_p-1:0] cache_req_metadata_i,
    input  logic [num_cache_req_lp-1:0]                        cache_req_metadata_v_i,
    output logic [num_cache_req_lp-1:0]                        cache_req_complete_o,
    output logic [req_width_p-1:0]                             cache_req_o,
    output logic                                               cache_req_v_o,
    input  logic                                               cache_req_ready_i,
    output logic [metadata_width_p-1:0]                        cache_req_metadata_o,
    output logic                                               cache_req_metadata_v_o,
    input  logic                                               cache_req_complete_i,
    output logic                                               owner_o
);

    bp_cache_req_arb_state_e r_state;
    logic [req_width_p-1:0]      r_req;
    logic [metadata_width_p-1:0] r_meta;
    logic                        r_owner;
    logic                        r_last_owner;
    logic                        r_captured;
    logic                        r_meta_v;

    logic w_idle;
    logic w_busy;
    logic w_sel;
    logic w_grant;
    logic w_meta_hit;
    logic w_have_meta;

    assign w_idle      = (r_state == e_arb_idle);
    assign w_busy      = (r_state == e_arb_busy);
    assign w_sel       = rr_pick(cache_req_v_i, r_last_owner);
    assign w_grant     = w_idle & cache_req_v_i[w_sel];
    assign w_meta_hit  = cache_req_metadata_v_i[r_owner];
    assign w_have_meta = r_captured | w_meta_hit;

    assign cache_req_ready_o      = w_idle ? {w_sel, ~w_sel} : 2'b00;
    assign cache_req_complete_o   = (w_busy & cache_req_complete_i) ? {r_owner, ~r_owner} : 2'b00;
    assign cache_req_v_o          = (r_state == e_arb_send);
    assign cache_req_o            = r_req;
    assign cache_req_metadata_o   = r_meta;
    assign cache_req_metadata_v_o = r_meta_v;
    assign owner_o                = r_owner;

    // Control FSM; metadata may arrive any time from the grant cycle until completion.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= e_arb_idle;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_captured   <= 1'b0;
            r_meta_v     <= 1'b0;
        end else begin
            r_meta_v <= 1'b0;
            case (r_state)
                e_arb_idle: begin
                    if (w_grant) begin
                        r_owner    <= w_sel;
                        r_captured <= cache_req_metadata_v_i[w_sel];
                        r_state    <= e_arb_send;
                    end
                end
                e_arb_send: begin
                    if (w_meta_hit) begin
                        r_captured <= 1'b1;
                    end
                    if (cache_req_ready_i) begin
                        if (w_have_meta) begin
                            r_state  <= e_arb_busy;
                            r_meta_v <= 1'b1;
                        end else begin
                            r_state <= e_arb_meta;
                        end
                    end
                end
                e_arb_meta: begin
                    if (w_meta_hit) begin
                        r_captured <= 1'b1;
                        r_state    <= e_arb_busy;
                        r_meta_v   <= 1'b1;
                    end
                end
                e_arb_busy: begin
                    if (cache_req_complete_i) begin
                        r_last_owner <= r_owner;
                        r_captured   <= 1'b0;
                        r_state      <= e_arb_idle;
                    end
                end
                default: r_state <= e_arb_idle;
            endcase
        end
    end

    // Payload registers carry no reset; they are only meaningful behind a valid.
    always_ff @(posedge clk_i) begin
        if (w_grant) begin
            r_req <= cache_req_i[w_sel];
        end
        if (w_grant && cache_req_metadata_v_i[w_sel]) begin
            r_meta <= cache_req_metadata_i[w_sel];
        end else if (!w_idle && w_meta_hit) begin
            r_meta <= cache_req_metadata_i[r_owner];
        end
    end

    // A completion with nothing outstanding is dropped but flagged in simulation.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(cache_req_complete_i && !w_busy))
            else $warning("stray cache_req_complete_i outside BUSY ignored");
        end
    end

endmodule

// File: tb/tb_bp_cache_req_arbiter.sv
// Directed scenarios plus random traffic against a transaction-level reference model.
module tb_bp_cache_req_arbiter;

    logic             clk;
    logic             reset_n_i;
    logic [1:0][63:0] req_in;
    logic [1:0]       cache_req_v_i;
    logic [1:0]       cache_req_ready_o;
    logic [1:0][7:0]  md_in;
    logic [1:0]       metadata_v_i;
    logic [1:0]       complete_o;
    logic [63:0]      req_o;
    logic             req_v_o;
    logic             ready_i;
    logic [7:0]       meta_o;
    logic             meta_v_o;
    logic             complete_i;
    logic             owner_o;

    bp_cache_req_arbiter #(.req_width_p(64), .metadata_width_p(8)) dut (
        .clk_i                  (clk),
        .reset_n_i              (reset_n_i),
        .cache_req_i            (req_in),
        .cache_req_v_i          (cache_req_v_i),
        .cache_req_ready_o      (cache_req_ready_o),
        .cache_req_metadata_i   (md_in),
        .cache_req_metadata_v_i (metadata_v_i),
        .cache_req_complete_o   (complete_o),
        .cache_req_o            (req_o),
        .cache_req_v_o          (req_v_o),
        .cache_req_ready_i      (ready_i),
        .cache_req_metadata_o   (meta_o),
        .cache_req_metadata_v_o (meta_v_o),
        .cache_req_complete_i   (complete_i),
        .owner_o                (owner_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one outstanding transaction described by progress flags.
    bit          m_active;
    bit          m_sent;
    bit          m_have;
    bit          m_pulse;
    bit          m_meta_known;
    int          m_owner;
    int          m_last;
    logic [63:0] m_req;
    logic [7:0]  m_meta;

    logic [1:0]  obs_ready;
    logic [1:0]  obs_cmp;
    logic        obs_v;
    logic [63:0] obs_req;
    logic        obs_meta_v;
    logic [7:0]  obs_meta;
    logic        obs_owner;

    logic [1:0]  rv;
    logic [1:0]  rmv;
    logic        rrdy;
    logic        rcmp;

    function automatic int pick(input logic [1:0] v, input int last);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return 1 - last;
    endfunction

    function automatic bit model_busy();
        return m_active && m_sent && m_have;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, compare all outputs to the model, then advance the model.
    task automatic step(input logic [1:0] v, input logic [1:0] mv, input logic rdy, input logic cmp);
        logic [1:0] exp_ready;
        logic [1:0] exp_cmp;
        int         sel;
        bit         busy;
        cache_req_v_i = v;
        metadata_v_i  = mv;
        ready_i       = rdy;
        complete_i    = cmp;
        #1;
        busy      = model_busy();
        sel       = pick(v, m_last);
        exp_ready = m_active ? 2'b00 : ((sel == 1) ? 2'b10 : 2'b01);
        exp_cmp   = (busy && cmp) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
        check("ready", 64'(cache_req_ready_o), 64'(exp_ready));
        check("req_v", 64'(req_v_o), 64'(m_active && !m_sent));
        if (m_active && !m_sent) check("req_data", req_o, m_req);
        check("meta_v", 64'(meta_v_o), 64'(m_pulse));
        if (m_meta_known) check("meta_data", 64'(meta_o), 64'(m_meta));
        check("complete", 64'(complete_o), 64'(exp_cmp));
        check("owner", 64'(owner_o), 64'(m_owner));
        obs_ready  = cache_req_ready_o;
        obs_cmp    = complete_o;
        obs_v      = req_v_o;
        obs_req    = req_o;
        obs_meta_v = meta_v_o;
        obs_meta   = meta_o;
        obs_owner  = owner_o;

        m_pulse = 1'b0;
        if (!m_active) begin
            if (v[sel]) begin
                m_active = 1'b1;
                m_sent   = 1'b0;
                m_owner  = sel;
                m_req    = req_in[sel];
                m_have   = mv[sel];
                if (mv[sel]) begin
                    m_meta       = md_in[sel];
                    m_meta_known = 1'b1;
                end
            end
        end else begin
            if (mv[m_owner]) begin
                m_meta       = md_in[m_owner];
                m_meta_known = 1'b1;
            end
            if (busy) begin
                if (cmp) begin
                    m_active = 1'b0;
                    m_have   = 1'b0;
                    m_last   = m_owner;
                end
            end else begin
                if (rdy) m_sent = 1'b1;
                m_have = m_have | mv[m_owner];
                if (m_sent && m_have) m_pulse = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Async reset mid-cycle; outputs are checked while reset is still low.
    task automatic apply_reset(input logic cmp);
        cache_req_v_i = 2'b00;
        metadata_v_i  = 2'b00;
        ready_i       = 1'b0;
        complete_i    = cmp;
        #2;
        reset_n_i = 1'b0;
        #1;
        m_active = 1'b0;
        m_sent   = 1'b0;
        m_have   = 1'b0;
        m_pulse  = 1'b0;
        m_owner  = 0;
        m_last   = 1;
        check("rst_req_v", 64'(req_v_o), 64'(0));
        check("rst_meta_v", 64'(meta_v_o), 64'(0));
        check("rst_complete", 64'(complete_o), 64'(0));
        check("rst_owner", 64'(owner_o), 64'(0));
        check("rst_ready", 64'(cache_req_ready_o), 64'(2'b01));
        @(negedge clk);
        reset_n_i  = 1'b1;
        complete_i = 1'b0;
    endtask

    initial begin
        reset_n_i     = 1'b1;
        req_in        = '0;
        md_in         = '0;
        cache_req_v_i = 2'b00;
        metadata_v_i  = 2'b00;
        ready_i       = 1'b0;
        complete_i    = 1'b0;
        m_meta_known  = 1'b0;
        m_req         = '0;
        m_meta        = '0;
        @(negedge clk);
        apply_reset(1'b0);

        // Single dcache request.
        req_in[1] = 64'hABCD;
        step(2'b10, 2'b00, 1'b1, 1'b0);
        check("s1_ready", 64'(obs_ready), 64'(2'b10));
        step(2'b00, 2'b00, 1'b1, 1'b0);
        check("s1_req_v", 64'(obs_v), 64'(1));
        check("s1_req", obs_req, 64'hABCD);
        md_in[1] = 8'h05;
        step(2'b00, 2'b10, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b1);
        check("s1_meta_v", 64'(obs_meta_v), 64'(1));
        check("s1_meta", 64'(obs_meta), 64'(8'h05));
        check("s1_complete", 64'(obs_cmp), 64'(2'b10));
        step(2'b00, 2'b00, 1'b0, 1'b0);

        // Tie after reset: icache first, then dcache.
        apply_reset(1'b0);
        req_in[0] = 64'h1111;
        req_in[1] = 64'h2222;
        step(2'b11, 2'b00, 1'b0, 1'b0);
        check("tie_ready0", 64'(obs_ready), 64'(2'b01));
        step(2'b11, 2'b00, 1'b1, 1'b0);
        check("tie_owner0", 64'(obs_owner), 64'(0));
        step(2'b11, 2'b01, 1'b0, 1'b0);
        step(2'b11, 2'b00, 1'b0, 1'b1);
        check("tie_complete0", 64'(obs_cmp), 64'(2'b01));
        step(2'b11, 2'b00, 1'b0, 1'b0);
        check("tie_ready1", 64'(obs_ready), 64'(2'b10));
        step(2'b00, 2'b10, 1'b1, 1'b0);
        check("tie_owner1", 64'(obs_owner), 64'(1));
        step(2'b00, 2'b00, 1'b0, 1'b1);
        check("tie_complete1", 64'(obs_cmp), 64'(2'b10));

        // Early metadata with a stalled LCE.
        md_in[0] = 8'h3C;
        step(2'b01, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 2'b00, 1'b0, 1'b0);
            check("early_no_meta", 64'(obs_meta_v), 64'(0));
        end
        step(2'b00, 2'b00, 1'b1, 1'b0);
        check("early_hs_no_meta", 64'(obs_meta_v), 64'(0));
        step(2'b00, 2'b00, 1'b0, 1'b0);
        check("early_meta_v", 64'(obs_meta_v), 64'(1));
        check("early_meta", 64'(obs_meta), 64'(8'h3C));
        step(2'b00, 2'b00, 1'b0, 1'b0);
        check("early_once", 64'(obs_meta_v), 64'(0));

        // Stray signals: non-owner metadata in BUSY, completion in IDLE.
        md_in[1] = 8'h99;
        step(2'b00, 2'b10, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0);
        check("stray_meta_hold", 64'(obs_meta), 64'(8'h3C));
        step(2'b00, 2'b00, 1'b0, 1'b1);
        check("stray_owner_cmp", 64'(obs_cmp), 64'(2'b01));
        step(2'b00, 2'b00, 1'b0, 1'b1);
        check("stray_idle_cmp", 64'(obs_cmp), 64'(2'b00));
        step(2'b00, 2'b00, 1'b0, 1'b0);

        // Reset while BUSY drops the transaction.
        step(2'b10, 2'b10, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b1, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0);
        check("midrst_busy_meta_v", 64'(obs_meta_v), 64'(1));
        apply_reset(1'b1);
        step(2'b11, 2'b00, 1'b0, 1'b0);
        check("midrst_tie_ready", 64'(obs_ready), 64'(2'b01));
        step(2'b00, 2'b00, 1'b0, 1'b0);
        check("midrst_tie_owner", 64'(obs_owner), 64'(0));

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) apply_reset(1'b0);
            req_in[0] = {$urandom, $urandom};
            req_in[1] = {$urandom, $urandom};
            md_in[0]  = 8'($urandom);
            md_in[1]  = 8'($urandom);
            rv   = 2'($urandom);
            rmv  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            rrdy = 1'($urandom);
            rcmp = model_busy() && ($urandom_range(0, 2) == 0);
            step(rv, rmv, rrdy, rcmp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
